// File: rtl/mem_map_pkg.sv
// Shared memory map for mem_bridge: region codes, peripheral addresses and
// KBD_STAT bit positions, plus the address decoder used by the bridge.
package mem_map_pkg;

    typedef enum logic [2:0] {
        RGN_NONE,
        RGN_RAM,
        RGN_LED,
        RGN_KSTAT,
        RGN_KDATA,
        RGN_TIMER
    } region_t;

    localparam logic [3:0]  RAM_NIBBLE = 4'h0;
    localparam logic [31:0] ADDR_LED   = 32'h1000_0000;
    localparam logic [31:0] ADDR_KSTAT = 32'h1000_0004;
    localparam logic [31:0] ADDR_KDATA = 32'h1000_0008;
    localparam logic [31:0] ADDR_TIMER = 32'h1000_000C;

    localparam int KSTAT_NONEMPTY_BIT = 0;
    localparam int KSTAT_OVF_BIT      = 1;
    localparam int KSTAT_CLR_BIT      = 1;

    // Word-granular decode: byte-lane bits [1:0] never take part.
    function automatic region_t decode_region(input logic [29:0] word_addr);
        region_t rgn;
        rgn = RGN_NONE;
        if (word_addr[29:26] == RAM_NIBBLE)
            rgn = RGN_RAM;
        else if (word_addr == ADDR_LED[31:2])
            rgn = RGN_LED;
        else if (word_addr == ADDR_KSTAT[31:2])
            rgn = RGN_KSTAT;
        else if (word_addr == ADDR_KDATA[31:2])
            rgn = RGN_KDATA;
        else if (word_addr == ADDR_TIMER[31:2])
            rgn = RGN_TIMER;
        return rgn;
    endfunction

endpackage

// File: rtl/kbd_fifo.sv
// Keyboard scan-code FIFO with sticky overflow flag. A push into a full FIFO
// is accepted only when a pop happens in the same cycle.
module kbd_fifo #(
    parameter int DEPTH = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic [7:0] push_data,
    input  logic       pop,
    input  logic       clr_ovf,
    output logic [7:0] head,
    output logic       empty,
    output logic       full,
    output logic       overflow
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW + 1)'(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW:0]   count;
    logic          do_push;
    logic          do_pop;
    logic          ovf_event;

    assign empty     = (count == '0);
    assign full      = (count == FULL_CNT);
    assign do_pop    = pop && !empty;
    assign do_push   = push && (!full || do_pop);
    assign ovf_event = push && full && !do_pop;
    assign head      = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= push_data;
    end

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            // A coincident overflow outranks a clear request.
            if (ovf_event)
                overflow <= 1'b1;
            else if (clr_ovf)
                overflow <= 1'b0;
        end
    end

endmodule

// File: rtl/mem_bridge.sv
// CPU data-bus bridge to synchronous RAM, LED register, keyboard FIFO and an
// optional cycle timer enabled by MEM_BRIDGE_TIMER_EN.
module mem_bridge
    import mem_map_pkg::*;
#(
    parameter int RAM_AW      = 10,
    parameter int KFIFO_DEPTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       mem_addr,
    input  logic [31:0]       mem_write_data,
    input  logic              wren,
    output logic [31:0]       mem_read_data,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    output logic              ram_we,
    input  logic [31:0]       ram_rdata,
    input  logic              kbd_valid,
    input  logic [7:0]        kbd_data,
    output logic [15:0]       led,
    output logic              kbd_overflow
);
    region_t     rgn;
    region_t     rd_sel_q;
    logic [31:0] rd_data_q;
    logic [31:0] rd_next;
    logic [31:0] timer_val;
    logic        kdata_hit;
    logic        kdata_hit_q;
    logic        fifo_pop;
    logic        fifo_clr;
    logic [7:0]  fifo_head;
    logic        fifo_empty;
    logic        fifo_full;

    always_comb begin
        rgn = decode_region(mem_addr[31:2]);
`ifndef MEM_BRIDGE_TIMER_EN
        if (rgn == RGN_TIMER)
            rgn = RGN_NONE;
`endif
    end

    assign ram_addr  = mem_addr[RAM_AW+1:2];
    assign ram_wdata = mem_write_data;
    assign ram_we    = wren && (rgn == RGN_RAM);

    // Pop only on the first cycle of a KBD_DATA load, however long it is held.
    assign kdata_hit = !wren && (rgn == RGN_KDATA);
    assign fifo_pop  = kdata_hit && !kdata_hit_q && !fifo_empty;
    assign fifo_clr  = wren && (rgn == RGN_KSTAT) && mem_write_data[KSTAT_CLR_BIT];

    kbd_fifo #(
        .DEPTH(KFIFO_DEPTH)
    ) u_kbd_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (kbd_valid),
        .push_data(kbd_data),
        .pop      (fifo_pop),
        .clr_ovf  (fifo_clr),
        .head     (fifo_head),
        .empty    (fifo_empty),
        .full     (fifo_full),
        .overflow (kbd_overflow)
    );

`ifdef MEM_BRIDGE_TIMER_EN
    logic [31:0] timer_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            timer_q <= '0;
        else if (wren && (rgn == RGN_TIMER))
            timer_q <= mem_write_data;
        else
            timer_q <= timer_q + 32'd1;
    end

    assign timer_val = timer_q;
`else
    assign timer_val = '0;
`endif

    always_comb begin
        rd_next = '0;
        if (!wren) begin
            case (rgn)
                RGN_LED: rd_next = {16'h0, led};
                RGN_KSTAT: begin
                    rd_next[KSTAT_OVF_BIT]      = kbd_overflow;
                    rd_next[KSTAT_NONEMPTY_BIT] = !fifo_empty;
                end
                RGN_KDATA: if (!fifo_empty) rd_next = {24'h0, fifo_head};
                RGN_TIMER: rd_next = timer_val;
                default:   rd_next = '0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            led         <= '0;
            rd_sel_q    <= RGN_NONE;
            rd_data_q   <= '0;
            kdata_hit_q <= 1'b0;
        end else begin
            if (wren && (rgn == RGN_LED))
                led <= mem_write_data[15:0];
            rd_sel_q    <= wren ? RGN_NONE : rgn;
            rd_data_q   <= rd_next;
            kdata_hit_q <= kdata_hit;
        end
    end

    // The RAM registers its own read data, so RAM loads bypass rd_data_q.
    assign mem_read_data = (rd_sel_q == RGN_RAM) ? ram_rdata : rd_data_q;

endmodule

// File: tb/tb_mem_bridge.sv
// Directed self-checking bench for mem_bridge with a behavioural synchronous RAM.
module tb_mem_bridge;

    localparam int RAM_AW = 10;

    localparam logic [31:0] A_LED   = 32'h1000_0000;
    localparam logic [31:0] A_KSTAT = 32'h1000_0004;
    localparam logic [31:0] A_KDATA = 32'h1000_0008;
    localparam logic [31:0] A_TIMER = 32'h1000_000C;
    localparam logic [31:0] A_IDLE  = 32'h2000_0000;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [31:0]       mem_addr = A_IDLE;
    logic [31:0]       mem_write_data = '0;
    logic              wren = 1'b0;
    logic [31:0]       mem_read_data;
    logic [RAM_AW-1:0] ram_addr;
    logic [31:0]       ram_wdata;
    logic              ram_we;
    logic [31:0]       ram_rdata;
    logic              kbd_valid = 1'b0;
    logic [7:0]        kbd_data = '0;
    logic [15:0]       led;
    logic              kbd_overflow;

    logic [31:0] ram [2**RAM_AW];

    int n_vec = 0;
    int n_bad = 0;
    int we_pulses = 0;

    mem_bridge #(.RAM_AW(RAM_AW), .KFIFO_DEPTH(8)) dut (
        .clk(clk), .rst(rst), .mem_addr(mem_addr), .mem_write_data(mem_write_data),
        .wren(wren), .mem_read_data(mem_read_data), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_we(ram_we), .ram_rdata(ram_rdata),
        .kbd_valid(kbd_valid), .kbd_data(kbd_data), .led(led),
        .kbd_overflow(kbd_overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_we) begin
            ram[ram_addr] <= ram_wdata;
            we_pulses <= we_pulses + 1;
        end
        ram_rdata <= ram[ram_addr];
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        mem_addr  = A_IDLE;
        wren      = 1'b0;
        kbd_valid = 1'b0;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d);
        mem_addr = a; mem_write_data = d; wren = 1'b1;
        step();
        idle();
        step();
    endtask

    task automatic load(input logic [31:0] a, output logic [31:0] d);
        mem_addr = a; wren = 1'b0;
        step();
        d = mem_read_data;
        idle();
        step();
    endtask

    task automatic push(input logic [7:0] code);
        kbd_valid = 1'b1; kbd_data = code;
        step();
        kbd_valid = 1'b0;
    endtask

    task automatic test_reset();
        mem_addr = A_LED; wren = 1'b0;
        step();
        n_vec++; if (mem_read_data !== 32'h0) begin n_bad++; $display("FAIL reset_rdata got %h exp 0", mem_read_data); end
        n_vec++; if (led !== 16'h0) begin n_bad++; $display("FAIL reset_led got %h exp 0", led); end
        n_vec++; if (kbd_overflow !== 1'b0) begin n_bad++; $display("FAIL reset_ovf got %b exp 0", kbd_overflow); end
        idle();
        rst = 1'b0;
        step();
    endtask

    task automatic test_ram();
        logic [31:0] d;
        int base;
        base = we_pulses;
        mem_addr = 32'h0000_0010; mem_write_data = 32'hDEAD_BEEF; wren = 1'b1;
        #1;
        n_vec++; if (ram_we !== 1'b1) begin n_bad++; $display("FAIL ram_we_store got %b exp 1", ram_we); end
        n_vec++; if (ram_addr !== 10'd4) begin n_bad++; $display("FAIL ram_addr got %h exp 4", ram_addr); end
        step();
        idle();
        step();
        load(32'h0000_0010, d);
        n_vec++; if (d !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL ram_load got %h exp deadbeef", d); end
        n_vec++; if (we_pulses - base !== 1) begin n_bad++; $display("FAIL ram_we_pulses got %0d exp 1", we_pulses - base); end
        load(32'h0000_0013, d);
        n_vec++; if (d !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL ram_lowbits got %h exp deadbeef", d); end
    endtask

    task automatic test_led();
        logic [31:0] d;
        mem_addr = A_LED; mem_write_data = 32'h0001_A5A5; wren = 1'b1;
        #1;
        n_vec++; if (ram_we !== 1'b0) begin n_bad++; $display("FAIL led_no_ram_we got %b exp 0", ram_we); end
        step();
        idle();
        step();
        n_vec++; if (led !== 16'hA5A5) begin n_bad++; $display("FAIL led_value got %h exp a5a5", led); end
        load(A_LED, d);
        n_vec++; if (d !== 32'h0000_A5A5) begin n_bad++; $display("FAIL led_load got %h exp 0000a5a5", d); end
        load(A_LED | 32'h2, d);
        n_vec++; if (d !== 32'h0000_A5A5) begin n_bad++; $display("FAIL led_lowbits got %h exp 0000a5a5", d); end
    endtask

    task automatic test_unmapped();
        logic [31:0] d;
        store(32'h1000_0010, 32'hFFFF_FFFF);
        n_vec++; if (led !== 16'hA5A5) begin n_bad++; $display("FAIL unmapped_store led got %h exp a5a5", led); end
        load(32'h1000_0010, d);
        n_vec++; if (d !== 32'h0) begin n_bad++; $display("FAIL unmapped_load1 got %h exp 0", d); end
        load(32'h3000_0000, d);
        n_vec++; if (d !== 32'h0) begin n_bad++; $display("FAIL unmapped_load2 got %h exp 0", d); end
    endtask

    task automatic test_kbd_pop();
        logic [31:0] d;
        push(8'h1C);
        push(8'h32);
        mem_addr = A_KDATA; wren = 1'b0;
        step();
        n_vec++; if (mem_read_data !== 32'h1C) begin n_bad++; $display("FAIL kdata_first got %h exp 1c", mem_read_data); end
        step();
        step();
        idle();
        step();
        load(A_KSTAT, d);
        n_vec++; if (d !== 32'h1) begin n_bad++; $display("FAIL kstat_after_hold got %h exp 1", d); end
        load(A_KDATA, d);
        n_vec++; if (d !== 32'h32) begin n_bad++; $display("FAIL kdata_second got %h exp 32", d); end
        load(A_KDATA, d);
        n_vec++; if (d !== 32'h0) begin n_bad++; $display("FAIL kdata_empty got %h exp 0", d); end
        load(A_KSTAT, d);
        n_vec++; if (d !== 32'h0) begin n_bad++; $display("FAIL kstat_empty got %h exp 0", d); end
    endtask

    task automatic test_overflow();
        logic [31:0] d;
        for (int i = 0; i < 9; i++) push(8'h40 + 8'(i));
        n_vec++; if (kbd_overflow !== 1'b1) begin n_bad++; $display("FAIL ovf_set got %b exp 1", kbd_overflow); end
        load(A_KSTAT, d);
        n_vec++; if (d !== 32'h3) begin n_bad++; $display("FAIL ovf_kstat got %h exp 3", d); end
        store(A_KSTAT, 32'h2);
        n_vec++; if (kbd_overflow !== 1'b0) begin n_bad++; $display("FAIL ovf_clear got %b exp 0", kbd_overflow); end
        for (int i = 0; i < 8; i++) begin
            load(A_KDATA, d);
            n_vec++; if (d !== 32'h40 + 32'(i)) begin n_bad++; $display("FAIL ovf_read%0d got %h exp %h", i, d, 32'h40 + 32'(i)); end
        end
        load(A_KSTAT, d);
        n_vec++; if (d !== 32'h0) begin n_bad++; $display("FAIL ovf_drained got %h exp 0", d); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] d;
        for (int i = 0; i < 8; i++) push(8'h50 + 8'(i));
        // Pop and push in the same cycle while full.
        mem_addr = A_KDATA; wren = 1'b0; kbd_valid = 1'b1; kbd_data = 8'h58;
        step();
        n_vec++; if (mem_read_data !== 32'h50) begin n_bad++; $display("FAIL b2b_head got %h exp 50", mem_read_data); end
        n_vec++; if (kbd_overflow !== 1'b0) begin n_bad++; $display("FAIL b2b_no_ovf got %b exp 0", kbd_overflow); end
        idle();
        step();
        // Clear request coinciding with an overflow leaves the flag set.
        mem_addr = A_KSTAT; mem_write_data = 32'h2; wren = 1'b1; kbd_valid = 1'b1; kbd_data = 8'h59;
        step();
        idle();
        step();
        n_vec++; if (kbd_overflow !== 1'b1) begin n_bad++; $display("FAIL clr_vs_ovf got %b exp 1", kbd_overflow); end
        store(A_KSTAT, 32'h2);
        for (int i = 0; i < 8; i++) begin
            load(A_KDATA, d);
            n_vec++; if (d !== 32'h51 + 32'(i)) begin n_bad++; $display("FAIL b2b_read%0d got %h exp %h", i, d, 32'h51 + 32'(i)); end
        end
        load(A_KSTAT, d);
        n_vec++; if (d !== 32'h0) begin n_bad++; $display("FAIL b2b_drained got %h exp 0", d); end
    endtask

    task automatic test_timer();
        logic [31:0] d;
        logic [31:0] exp_next;
`ifdef MEM_BRIDGE_TIMER_EN
        exp_next = 32'h2;
`else
        exp_next = 32'h0;
`endif
        // Timer holds FFFF_FFFE in the cycle after the store; the load two
        // cycles after that sees the wrapped value.
        store(A_TIMER, 32'hFFFF_FFFE);
        step();
        load(A_TIMER, d);
        n_vec++; if (d !== 32'h0) begin n_bad++; $display("FAIL timer_wrap got %h exp 0", d); end
        load(A_TIMER, d);
        n_vec++; if (d !== exp_next) begin n_bad++; $display("FAIL timer_next got %h exp %h", d, exp_next); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] d;
        store(A_LED, 32'h0000_00FF);
        push(8'h11);
        for (int i = 0; i < 8; i++) push(8'h20);
        mem_addr = A_LED; wren = 1'b0;
        step();
        #2;
        rst = 1'b1;
        #1;
        n_vec++; if (mem_read_data !== 32'h0) begin n_bad++; $display("FAIL rstmid_rdata got %h exp 0", mem_read_data); end
        n_vec++; if (led !== 16'h0) begin n_bad++; $display("FAIL rstmid_led got %h exp 0", led); end
        n_vec++; if (kbd_overflow !== 1'b0) begin n_bad++; $display("FAIL rstmid_ovf got %b exp 0", kbd_overflow); end
        idle();
        step();
        rst = 1'b0;
        load(A_KSTAT, d);
        n_vec++; if (d !== 32'h0) begin n_bad++; $display("FAIL rstmid_kstat got %h exp 0", d); end
        load(A_TIMER, d);
        n_vec++; if (d > 32'd8) begin n_bad++; $display("FAIL rstmid_timer got %h exp <=8", d); end
        store(A_LED, 32'h0000_1234);
        load(A_LED, d);
        n_vec++; if (d !== 32'h0000_1234) begin n_bad++; $display("FAIL rstmid_led_after got %h exp 1234", d); end
    endtask

    initial begin
        for (int i = 0; i < 2**RAM_AW; i++) ram[i] = '0;
        test_reset();
        test_ram();
        test_led();
        test_unmapped();
        test_kbd_pop();
        test_overflow();
        test_back_to_back();
        test_timer();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_bridge.md
MEM_BRIDGE -- requirements
Module: mem_bridge

Interface
REQ-001 Parameters SHALL be: RAM_AW, 10, RAM word-address width; KFIFO_DEPTH, 8, keyboard FIFO entries (power of two).
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 mem_addr  input  32  CPU data byte address.
REQ-005 mem_write_data  input  32  CPU store data.
REQ-006 wren  input  1  CPU store enable; 0 means a load or no access.
REQ-007 mem_read_data  output  32  registered load data returned to CPU.
REQ-008 ram_addr  output  RAM_AW  word address to synchronous data RAM, equal to mem_addr[RAM_AW+1:2].
REQ-009 ram_wdata  output  32  RAM write data, equal to mem_write_data.
REQ-010 ram_we  output  1  RAM write enable.
REQ-011 ram_rdata  input  32  RAM read data, valid one cycle after ram_addr.
REQ-012 kbd_valid  input  1  one-cycle push strobe from keyboard receiver.
REQ-013 kbd_data  input  8  scan code accompanying kbd_valid.
REQ-014 led  output  16  LED register.
REQ-015 kbd_overflow  output  1  sticky FIFO overflow flag.

Function
REQ-016 Address decode SHALL be: mem_addr[31:28]==0x0 is RAM; 0x1000_0000 LED; 0x1000_0004 KBD_STAT; 0x1000_0008 KBD_DATA; 0x1000_000C TIMER; everything else is unmapped. mem_addr[1:0] SHALL be ignored.
REQ-017 ram_we SHALL equal wren AND RAM region, combinationally.
REQ-018 Load latency SHALL be one cycle: mem_read_data at edge N+1 reflects the address decoded during cycle N, for every region.
REQ-019 Unmapped loads SHALL return 0; unmapped stores SHALL be ignored.
REQ-020 LED store SHALL load led <= mem_write_data[15:0]; LED load returns {16'h0, led}.
REQ-021 KBD_STAT load SHALL return {30'h0, kbd_overflow, fifo_nonempty}; a store with mem_write_data[1]=1 SHALL clear kbd_overflow.
REQ-022 KBD_DATA load SHALL return {24'h0, head entry} and pop the FIFO exactly once per access: pop only in the first cycle the KBD_DATA address is presented with wren=0 (previous-cycle match flag register).
REQ-023 KBD_DATA load while FIFO empty SHALL return 0 and change no state.
REQ-024 kbd_valid while FIFO not full SHALL push kbd_data at the tail.
REQ-025 kbd_valid while full with no simultaneous pop SHALL drop the code and set kbd_overflow.
REQ-026 Simultaneous push and pop SHALL both take effect, count unchanged, including when full; no overflow in that case.
REQ-027 Read/write pointers SHALL wrap modulo KFIFO_DEPTH; count SHALL range 0..KFIFO_DEPTH.
REQ-028 If a clear-overflow store and an overflow event coincide, kbd_overflow SHALL end at 1.

Reset
REQ-029 While rst is high: mem_read_data=0, led=0, kbd_overflow=0, FIFO empty (pointers and count 0), pop-match flag 0, timer 0; RAM contents untouched.
REQ-030 Reset asserted mid-access SHALL abort it; the first access after deassertion is decoded normally.

Configuration
REQ-031 Macro MEM_BRIDGE_TIMER_EN defined: TIMER is a 32-bit free-running cycle counter, +1 per clock, wrapping 0xFFFF_FFFF to 0; a store loads mem_write_data and counting resumes from that value next cycle; a load returns the current value.
REQ-032 Macro undefined: no counter is instantiated, TIMER is unmapped (loads return 0, stores ignored).

Structure
REQ-033 Address constants, region codes and status-bit positions SHALL live in shared package mem_map_pkg.
REQ-034 The keyboard FIFO SHALL be a sub-module kbd_fifo (push, pop, data, empty, full, overflow).

Verification
REQ-035 Store 0xDEADBEEF to 0x0000_0010, then load it -> ram_we pulses once with ram_addr=4; mem_read_data=0xDEADBEEF one cycle after the load address.
REQ-036 Store 0x0001_A5A5 to 0x1000_0000 -> led=0xA5A5; load returns 0x0000_A5A5.
REQ-037 Push 0x1C,0x32; hold KBD_DATA load for 3 cycles; reload -> first returns 0x1C with exactly one pop; second returns 0x32; third load after empty returns 0, KBD_STAT=0.
REQ-038 Push 9 codes with depth 8 -> kbd_overflow=1, KBD_STAT=0x3; store 0x2 to KBD_STAT -> overflow 0, eight codes read back in order.
REQ-039 Full FIFO with push and pop in the same cycle -> count stays 8, no overflow.
REQ-040 With MEM_BRIDGE_TIMER_EN: store 0xFFFF_FFFE to TIMER, load two cycles later -> 0x0000_0000 (wrap); assert rst mid-run -> all outputs 0.
